// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: generates the 640x480@60 raster position for the page
// renderers, then delays sync/blanking so they line up with the page module's
// registered pixel and drives the 4-bit-per-channel DAC outputs.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_LAT = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Total delay from counter position to DAC outputs: the page fetch latency
    // plus the RGB output register.
    localparam int D       = PIPE_LAT + 1;

    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);

    logic [9:0]   hCnt_q, hCnt_d;
    logic [9:0]   vCnt_q, vCnt_d;
    logic         frameStart_q;
    // Bit 0 is stage 1 (one clock behind the counters); bit D-1 is stage D.
    logic [D-1:0] hsPipe_q;
    logic [D-1:0] vsPipe_q;
    logic [D-1:0] dePipe_q;
    logic [11:0]  rgb_q;

    logic hActiveC;
    logic vActiveC;
    logic activeC;
    logic hSyncC;
    logic vSyncC;

    // Decode the raster regions from the live counter values.
    always_comb begin
        hActiveC = (hCnt_q < H_ACT_C);
        vActiveC = (vCnt_q < V_ACT_C);
        activeC  = hActiveC && vActiveC;
        hSyncC   = (hCnt_q >= H_SYNC_LO) && (hCnt_q <= H_SYNC_HI);
        vSyncC   = (vCnt_q >= V_SYNC_LO) && (vCnt_q <= V_SYNC_HI);
    end

    // Next raster position: column wraps at end of line and bumps the row.
    always_comb begin
        hCnt_d = hCnt_q + 10'd1;
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST_C) begin
            hCnt_d = '0;
            if (vCnt_q == V_LAST_C) begin
                vCnt_d = '0;
            end else begin
                vCnt_d = vCnt_q + 10'd1;
            end
        end
    end

    // Raster counters and the undelayed start-of-frame pulse.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            frameStart_q <= 1'b0;
        end else begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            frameStart_q <= (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
        end
    end

    // Delay lines for sync/enable plus the RGB register, which captures the
    // page pixel only when the matching delayed enable says it is visible.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            hsPipe_q <= '0;
            vsPipe_q <= '0;
            dePipe_q <= '0;
            rgb_q    <= '0;
        end else begin
            hsPipe_q <= {hsPipe_q[D-2:0], hSyncC};
            vsPipe_q <= {vsPipe_q[D-2:0], vSyncC};
            dePipe_q <= {dePipe_q[D-2:0], activeC};
            if (dePipe_q[PIPE_LAT-1]) begin
                rgb_q <= pixel_data;
            end else begin
                rgb_q <= '0;
            end
        end
    end

    // Blanked positions address pixel 0 so the page never sees an
    // out-of-range address.
    assign x_pos       = hActiveC ? hCnt_q : 10'd0;
    assign y_pos       = vActiveC ? vCnt_q : 10'd0;
    assign frame_start = frameStart_q;
    assign hs          = hsPipe_q[D-1] ? SYNC_POL : ~SYNC_POL;
    assign vs          = vsPipe_q[D-1] ? SYNC_POL : ~SYNC_POL;
    assign de          = dePipe_q[D-1];
    assign r           = rgb_q[3:0];
    assign g           = rgb_q[7:4];
    assign b           = rgb_q[11:8];

endmodule
